// File: rtl/div_rs.sv
// rtl/div_rs.sv - sequential unsigned divider by repeated subtraction
// Optional zero-divisor check enabled by defining DIVRS_ZERO_CHK_EN.
module div_rs #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quot_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             done,
    output logic             busy,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_LDB,
        S_SUB,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;
    logic             b_zero;
    logic             r_ge_b;

`ifdef DIVRS_ZERO_CHK_EN
    logic             dz_q;
    assign b_zero   = (b_q == '0);
    assign div_zero = dz_q;
`else
    // Without the check a zero divisor spins in SUB; integrators avoid it.
    assign b_zero   = 1'b0;
    assign div_zero = 1'b0;
`endif

    assign r_ge_b   = (r_q >= b_q);
    assign quot_out = q_q;
    assign rem_out  = r_q;
    assign done     = (state == S_DONE);
    assign busy     = (state == S_LDA) || (state == S_LDB) || (state == S_SUB);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; start is only honoured when idle or finished
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LDA;
            S_LDA:   state_nx = S_LDB;
            S_LDB:   state_nx = S_SUB;
            S_SUB: begin
                if (b_zero) begin
                    state_nx = S_DONE;
                end else if (!r_ge_b) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  if (start) state_nx = S_LDA;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: load operands, then one subtraction per SUB cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            b_q <= '0;
            q_q <= '0;
        end else begin
            case (state)
                S_LDA: begin
                    r_q <= data_in;
                    q_q <= '0;
                end
                S_LDB: b_q <= data_in;
                S_SUB: begin
                    if (b_zero) begin
                        q_q <= '1;
                    end else if (r_ge_b) begin
                        r_q <= r_q - b_q;
                        q_q <= q_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIVRS_ZERO_CHK_EN
    // Zero-divisor flag: cleared on dividend load, set when SUB sees B==0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (state == S_LDA) begin
            dz_q <= 1'b0;
        end else if (state == S_SUB && b_zero) begin
            dz_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_div_rs.sv
// tb/tb_div_rs.sv - scoreboard bench for div_rs
module tb_div_rs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] quot_out;
    logic [15:0] rem_out;
    logic        done;
    logic        busy;
    logic        div_zero;

    div_rs #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .quot_out (quot_out),
        .rem_out  (rem_out),
        .done     (done),
        .busy     (busy),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          off;
        int          st;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input int eoff, input bit push, input bit pulse_mid);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'($urandom);
        e.q = eq; e.r = er; e.dz = edz; e.off = eoff; e.st = cyc + 1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        data_in = a;
        check("lda_done_low", {31'd0, done}, 32'd0);
        check("lda_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = 16'($urandom);
        if (pulse_mid) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (!done && i < bound) begin
            @(negedge clk);
            i++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("quot", {16'd0, quot_out}, {16'd0, e.q});
                        check("rem", {16'd0, rem_out}, {16'd0, e.r});
                        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                        check("latency", 32'(cyc - e.st + 1), 32'(e.off));
                    end
                end
                prev_done = done;
            end
        join_none

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_quot", {16'd0, quot_out}, 32'd0);
        check("rst_rem", {16'd0, rem_out}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 100 / 7 = 14 r 2, done at t+18, held until next start
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b1, 1'b0);
        wait_done(100);
        repeat (5) @(negedge clk);
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_quot", {16'd0, quot_out}, 32'd14);
        check("hold_rem", {16'd0, rem_out}, 32'd2);

        // 5 / 9 = 0 r 5, then back-to-back 81 / 9 = 9 r 0 from DONE
        issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 4, 1'b1, 1'b0);
        wait_done(100);
        issue(16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 13, 1'b1, 1'b0);
        wait_done(100);

        // start pulsed during SUB is ignored
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b1, 1'b1);
        wait_done(100);

        // Zero divisor
`ifdef DIVRS_ZERO_CHK_EN
        issue(16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 4, 1'b1, 1'b0);
        wait_done(100);
`else
        issue(16'd42, 16'd0, 16'd0, 16'd0, 1'b0, 0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("nz_busy", {31'd0, busy}, 32'd1);
        check("nz_done", {31'd0, done}, 32'd0);
        check("nz_rem", {16'd0, rem_out}, 32'd42);
        check("nz_dz", {31'd0, div_zero}, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        // Mid-operation reset during 1000 / 3
        issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_quot", {16'd0, quot_out}, 32'd0);
        check("mid_rem", {16'd0, rem_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 7, 1'b1, 1'b0);
        wait_done(100);

        // Worst case 65535 / 1
        issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65539, 1'b1, 1'b0);
        wait_done(70000);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div_rs.md
# div_rs

Sequential unsigned divider by repeated subtraction: the inverse companion of the team's repeated-addition multiplier, using the same operand protocol. After a `start` pulse it loads a dividend and then a divisor from one shared `data_in` bus on consecutive cycles. It then subtracts the divisor once per cycle until the remainder is smaller than the divisor, and raises `done` with quotient and remainder held stable.

## Interface
- `WIDTH`, 16, operand/result width in bits
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous and active-high; one clock, no other reset
- `start`  in  1  begin an operation; sampled only in IDLE or DONE
- `data_in`  in  WIDTH  dividend in LDA cycle, divisor in LDB cycle
- `quot_out`  out  WIDTH  quotient register (valid while `done`=1)
- `rem_out`  out  WIDTH  remainder register (valid while `done`=1)
- `done`  out  1  result valid; high for the whole DONE state
- `busy`  out  1  high in LDA, LDB, SUB
- `div_zero`  out  1  divisor was zero; valid while `done`=1

## Operation
- Registers: R (remainder/working dividend), B (divisor), Q (quotient); `rem_out`=R, `quot_out`=Q.
- States: IDLE, LDA, LDB, SUB, DONE.
- IDLE: `start`=1 -> LDA; else stay.
- LDA: R<=`data_in`, Q<=0, `div_zero`<=0 -> LDB.
- LDB: B<=`data_in` -> SUB.
- SUB, evaluated in priority order:
  - If B==0 (with the macro): Q<=all ones, R unchanged, `div_zero`<=1 -> DONE.
  - Else if R>=B: R<=R-B, Q<=Q+1, stay in SUB.
  - Else -> DONE.
- DONE: outputs frozen. `start`=1 -> LDA (back-to-back operation); else stay.
- `start` in LDA, LDB or SUB is ignored; no queuing.
- `data_in` is don't-care outside LDA and LDB.
- Arithmetic is unsigned WIDTH-bit; R>=B compare is unsigned. Q cannot overflow, since Q<=dividend.

## Timing
- Reset, asynchronous: state=IDLE, Q=0, R=0, B=0, `done`=0, `busy`=0, `div_zero`=0. Applies immediately, including mid-operation; the operation is aborted with no result.
- With `start` sampled high at edge of cycle t:
  - LDA occupies cycle t+1; the dividend must be on `data_in` then.
  - LDB occupies cycle t+2; the divisor must be on `data_in` then.
  - SUB occupies cycles t+3 .. t+3+Q, i.e. Q+1 cycles.
  - `done`=1 from cycle t+4+Q.
- Zero divisor: `done` at t+4.
- Worst case: dividend 2^WIDTH-1, divisor 1 -> `done` at t+2^WIDTH+3.
- `done`, `busy`, `div_zero` are decoded from registered state/flags; no combinational path from inputs to outputs.
- `done` falls in the cycle after `start` is sampled in DONE (state LDA).

## Configuration
- `DIVRS_ZERO_CHK_EN` defined: the zero-divisor check in SUB is present, with behaviour as above.
- Not defined:
  - The check logic is removed and `div_zero` is tied 0.
  - A zero divisor keeps the block in SUB indefinitely: R unchanged, Q incrementing and wrapping, until `rst`.
  - System integrators guarantee a nonzero divisor.

## Test plan
- Reset value check: assert `rst` asynchronously between edges -> all outputs 0 immediately, state IDLE.
- Normal division: `start`, then 100, then 7 -> `quot_out`=14, `rem_out`=2, `div_zero`=0. `done` rises at t+18 and holds until next `start`.
- Small dividend and extreme quotient:
  - 5, then 9 -> Q=0, R=5, `done` at t+4.
  - 65535, then 1 -> Q=65535, R=0, `done` at t+65539.
- Zero divisor (macro on): 42, then 0 -> `div_zero`=1, Q=16'hFFFF, R=42, `done` at t+4.
- Protocol robustness:
  - `start` pulsed during SUB is ignored; the result is unchanged.
  - `start` in DONE with 81, then 9 -> Q=9, R=0, with `done` low for the duration.
- Mid-operation reset: `rst` pulse during SUB of 1000/3 -> `busy` and `done` drop at once, Q=R=0. A following `start` with 10, then 3 -> Q=3, R=1.
